// File: rtl/rom_fetch_if.sv
// Valid/ready read front-end for a single-port ROM with a 1-cycle registered read.
// Optional ROM_FETCH_ERR_EN: misaligned requests return in order with rsp_err=1 and zero data.
module rom_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    logic                  pend_v_reg, pend_v_next;
    logic                  skid_v_reg, skid_v_next;
    logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                  req_fire, rsp_fire, req_is_err;
    logic                  pend_err, skid_err, pend_load;
    logic [DATA_WIDTH-1:0] pend_data;

`ifdef ROM_FETCH_ERR_EN
    logic pend_err_reg, pend_err_next;
    logic skid_err_reg, skid_err_next;

    assign req_is_err = |req_addr[1:0];
    assign pend_err   = pend_err_reg;
    assign skid_err   = skid_err_reg;
`else
    logic unused_lsb;

    assign unused_lsb = ^req_addr[1:0];
    assign req_is_err = 1'b0;
    assign pend_err   = 1'b0;
    assign skid_err   = 1'b0;
`endif

    // An error entry never clocked the ROM, so its slot carries no data.
    assign pend_data = pend_err ? '0 : rom_dout;

    always_comb begin
        req_ready = !(pend_v_reg && skid_v_reg) && !rst;
        req_fire  = req_valid && req_ready;
        rsp_valid = skid_v_reg || pend_v_reg;
        rsp_fire  = rsp_valid && rsp_ready;
        rsp_data  = skid_v_reg ? skid_data_reg : pend_data;
        rsp_err   = skid_v_reg ? skid_err : pend_err;
        rom_ce    = req_fire && !req_is_err;
        rom_addr  = rom_ce ? req_addr[ADDR_WIDTH+1:2] : '0;
    end

    always_comb begin
        skid_v_next    = skid_v_reg;
        skid_data_next = skid_data_reg;
        pend_v_next    = pend_v_reg;
        pend_load      = 1'b0;
`ifdef ROM_FETCH_ERR_EN
        skid_err_next  = skid_err_reg;
        pend_err_next  = pend_err_reg;
`endif
        if (skid_v_reg) begin
            if (rsp_fire) begin
                skid_v_next = 1'b0;
            end
            if (!pend_v_reg) begin
                pend_load = 1'b1;
            end
        end else if (pend_v_reg) begin
            if (rsp_fire) begin
                pend_load = 1'b1;
            end else if (req_fire) begin
                // Save the ROM output before the new read overwrites it.
                skid_v_next    = 1'b1;
                skid_data_next = pend_data;
`ifdef ROM_FETCH_ERR_EN
                skid_err_next  = pend_err_reg;
`endif
                pend_load      = 1'b1;
            end
        end else begin
            pend_load = 1'b1;
        end

        if (pend_load) begin
            pend_v_next = req_fire;
`ifdef ROM_FETCH_ERR_EN
            pend_err_next = req_fire && req_is_err;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_reg    <= 1'b0;
            skid_v_reg    <= 1'b0;
            skid_data_reg <= '0;
`ifdef ROM_FETCH_ERR_EN
            pend_err_reg  <= 1'b0;
            skid_err_reg  <= 1'b0;
`endif
        end else begin
            pend_v_reg    <= pend_v_next;
            skid_v_reg    <= skid_v_next;
            skid_data_reg <= skid_data_next;
`ifdef ROM_FETCH_ERR_EN
            pend_err_reg  <= pend_err_next;
            skid_err_reg  <= skid_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_rom_fetch_if.sv
// Randomized bench for rom_fetch_if against an in-order response queue model.
// Define ROM_FETCH_ERR_EN for both bench and DUT to exercise the misaligned-error path.
module tb_rom_fetch_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rom_ce;
    logic [7:0]  rom_addr;
    logic [31:0] rom_dout = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_data[$];
    logic        q_err[$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data;
    logic        stall_err;

    always #5 clk = ~clk;

    rom_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    function automatic logic [31:0] word(input logic [7:0] i);
        return 32'h01010101 * {24'd0, i};
    endfunction

    // Behavioural boot ROM: registered read, output held while ce is low.
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= word(rom_addr);
    end

    function automatic logic addr_is_err(input logic [9:0] a);
`ifdef ROM_FETCH_ERR_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [9:0] a, input logic rr, output logic acc);
        logic exp_rdy, exp_ce, exp_v;
        @(negedge clk);
        rst = 1'b0;
        req_valid = v;
        req_addr = a;
        rsp_ready = rr;
        #1;
        exp_rdy = q_data.size() < 2;
        exp_v = q_data.size() != 0;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            check("rsp_data", rsp_data, q_data[0]);
            check("rsp_err", rsp_err, q_err[0]);
        end
        if (stall_prev) begin
            check("stable_data", rsp_data, stall_data);
            check("stable_err", rsp_err, stall_err);
        end
        acc = v && exp_rdy;
        exp_ce = acc && !addr_is_err(a);
        check("rom_ce", rom_ce, exp_ce);
        check("rom_addr", rom_addr, exp_ce ? {24'd0, a[9:2]} : 32'd0);
        stall_prev = exp_v && !rr;
        stall_data = rsp_data;
        stall_err = rsp_err;
        $display("cyc v=%0b a=%h rr=%0b | rdy=%0b ce=%0b ra=%h | rv=%0b rd=%h re=%0b",
                 v, a, rr, req_ready, rom_ce, rom_addr, rsp_valid, rsp_data, rsp_err);
        @(posedge clk);
        if (exp_v && rr) begin
            void'(q_data.pop_front());
            void'(q_err.pop_front());
        end
        if (acc) begin
            q_data.push_back(addr_is_err(a) ? 32'd0 : word(a[9:2]));
            q_err.push_back(addr_is_err(a));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_addr = 10'h004;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rom_ce", rom_ce, 1'b0);
        check("rst_rom_addr", rom_addr, 32'd0);
        $display("reset applied");
        q_data.delete();
        q_err.delete();
        stall_prev = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 10'h000, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        logic rr;
        int tries;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        rsp_ready = 1'b0;
        do_reset();

        // Back-to-back at full throughput
        drive_cycle(1'b1, 10'h000, 1'b1, acc);
        drive_cycle(1'b1, 10'h004, 1'b1, acc);
        drive_cycle(1'b1, 10'h008, 1'b1, acc);
        idle(2);

        // Fill both slots, then release
        drive_cycle(1'b1, 10'h010, 1'b0, acc);
        drive_cycle(1'b1, 10'h014, 1'b0, acc);
        drive_cycle(1'b1, 10'h018, 1'b0, acc);
        drive_cycle(1'b1, 10'h018, 1'b1, acc);
        drive_cycle(1'b1, 10'h018, 1'b1, acc);
        check("full_then_accept", acc, 1'b1);
        idle(3);

        // Toggling rsp_ready over 16 sequential words
        rr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 8) begin
                drive_cycle(1'b1, 10'(i * 4), rr, acc);
                rr = ~rr;
                tries++;
            end
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 10'h000, rr, acc);
            rr = ~rr;
        end

        // Reset with two outstanding
        drive_cycle(1'b1, 10'h020, 1'b0, acc);
        drive_cycle(1'b1, 10'h024, 1'b0, acc);
        do_reset();
        drive_cycle(1'b0, 10'h000, 1'b1, acc);
        drive_cycle(1'b1, 10'h00C, 1'b1, acc);
        idle(2);

        // Misaligned handling, with and without backpressure
        drive_cycle(1'b1, 10'h004, 1'b1, acc);
        drive_cycle(1'b1, 10'h005, 1'b1, acc);
        drive_cycle(1'b1, 10'h008, 1'b1, acc);
        idle(2);
        drive_cycle(1'b1, 10'h004, 1'b0, acc);
        drive_cycle(1'b1, 10'h006, 1'b0, acc);
        drive_cycle(1'b0, 10'h000, 1'b0, acc);
        idle(3);

        // Top-of-ROM wrap
        drive_cycle(1'b1, 10'h3FC, 1'b1, acc);
        idle(2);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                            1'($urandom_range(0, 2) != 0), acc);
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
